control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Sequential front half of the SAP1 control unit; sits directly upstream of the instruction decoder.
//  Holds the instruction register, the microstep counter, the ALU flag register and the run/halt state.
//  Drives the decoder's instruction, step and zero/carry/odd inputs, and consumes the decoder's
//  halt, adv, II, IO and EL strobes. Also counts retired instructions for debug.
// PARAMETERS
//  BUS_WIDTH          8   shared data bus width
//  INSTRUCTION_WIDTH  4   opcode width, taken from the upper bits of the instruction register
//  INSTRUCTION_STEPS  8   microsteps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
//  COUNT_WIDTH        16  retired-instruction counter width
// PORTS
//  i_clk            in   1                   system clock; all state changes on the rising edge
//  i_reset          in   1                   synchronous, active-high reset
//  i_bus            in   BUS_WIDTH           bus value, loaded into the IR when i_instrregi is high
//  i_instrregi      in   1                   decoder II strobe
//  i_instrrego      in   1                   decoder IO strobe
//  i_adv            in   1                   decoder ADV: end of instruction
//  i_halt           in   1                   decoder HLT
//  i_alulatchf      in   1                   decoder EL: latch flags
//  i_alu_zero       in   1                   combinational ALU flag: result is zero
//  i_alu_carry      in   1                   combinational ALU flag: carry out
//  i_alu_odd        in   1                   combinational ALU flag: result is odd
//  i_manual         in   1                   single-step mode select (see CONFIGURATION)
//  i_step_pulse     in   1                   one-cycle pulse that grants one microstep
//  o_instruction    out  INSTRUCTION_WIDTH   IR[BUS_WIDTH-1 -: INSTRUCTION_WIDTH], to decoder
//  o_step           out  STEP_WIDTH          current microstep, to decoder
//  o_zero           out  1                   latched zero flag
//  o_carry          out  1                   latched carry flag
//  o_odd            out  1                   latched odd flag
//  o_operand        out  BUS_WIDTH           low (BUS_WIDTH-INSTRUCTION_WIDTH) bits of IR, zero-extended
//  o_operand_oe     out  1                   i_instrrego & running; bus driver enable
//  o_running        out  1                   1 in RUN, 0 in HALTED
//  o_retired        out  COUNT_WIDTH         count of completed instructions
// BEHAVIOUR
//  Reset: IR=0, step=0, flags=0, retired=0, state=RUN. So o_instruction=0, o_step=0,
//    o_operand_oe=0, o_running=1.
//  "advance" = state==RUN, plus the single-step gate when CONFIGURATION enables it.
//  FSM RUN -> HALTED when advance & i_halt. HALTED is left only by i_reset.
//  In HALTED, IR, step, flags and retired are all frozen, and o_operand_oe is forced to 0.
//  Step counter, when advance:
//    - i_halt: hold.
//    - else i_adv: step <= 0, and retired <= retired+1 (wraps modulo 2^COUNT_WIDTH).
//    - else step == INSTRUCTION_STEPS-1: step <= 0. Overflow wrap; retired is not incremented.
//    - else step <= step+1.
//  IR: when advance & i_instrregi, IR <= i_bus. This is visible to the decoder on the next cycle.
//    II and step increment in the same cycle both take effect.
//  Flags: when advance & i_alulatchf, {zero,carry,odd} <= {i_alu_zero,i_alu_carry,i_alu_odd}.
//    Otherwise they hold. Flags are not cleared by i_adv.
//  Latency: every register output updates one cycle after its qualifying strobe.
//    o_operand_oe is combinational.
//  Simultaneous events:
//    - i_halt+i_adv: halt wins; step holds, retired does not increment.
//    - i_halt+i_alulatchf or i_halt+i_instrregi: the load still happens in that final RUN cycle.
//  i_reset asserted mid-instruction: all state returns to reset values on the next edge, in any state.
// CONFIGURATION
//  Macro CONTROL_SEQUENCER_SINGLE_STEP_EN.
//  Defined: when i_manual=1, advance additionally requires i_step_pulse=1, so one pulse moves
//    exactly one microstep. With i_manual=0, free-running.
//  Undefined: i_manual and i_step_pulse are ignored; the sequencer is always free-running.
//  Ports exist in both builds.
// TESTING
//  1. Reset, then 8 cycles with no strobes -> o_step 0..7 then 0; retired stays 0.
//  2. i_bus=8'h1A, II at step1, adv at step4 -> o_instruction=4'h1, o_operand=8'h0A,
//     step 0 after adv, retired=1.
//  3. EL with alu {z,c,o}={1,0,1} -> o_zero=1, o_odd=1 next cycle; held through adv and
//     later steps until the next EL.
//  4. i_halt=1 together with i_adv at step 2 -> o_running=0, o_step stays 2, retired unchanged;
//     further II/EL/IO ignored, o_operand_oe=0; i_reset -> o_running=1, all outputs 0.
//  5. i_reset asserted at step 5 with flags set -> next cycle step=0, flags=0, IR=0.
//  6. Build with CONTROL_SEQUENCER_SINGLE_STEP_EN, i_manual=1: 10 idle cycles -> step frozen;
//     3 single pulses -> step advances exactly 3.
//     Build without the macro: same stimulus -> step free-runs.

Source files
------------

// File: rtl/control_sequencer.sv
// SAP1 control unit front half: instruction register, microstep counter, ALU flags, run/halt state.
// Optional macro CONTROL_SEQUENCER_SINGLE_STEP_EN gates advancement on i_step_pulse when i_manual=1.
module control_sequencer #(
    parameter  int BUS_WIDTH         = 8,
    parameter  int INSTRUCTION_WIDTH = 4,
    parameter  int INSTRUCTION_STEPS = 8,
    parameter  int COUNT_WIDTH       = 16,
    localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [BUS_WIDTH-1:0]         i_bus,
    input  logic                         i_instrregi,
    input  logic                         i_instrrego,
    input  logic                         i_adv,
    input  logic                         i_halt,
    input  logic                         i_alulatchf,
    input  logic                         i_alu_zero,
    input  logic                         i_alu_carry,
    input  logic                         i_alu_odd,
    input  logic                         i_manual,
    input  logic                         i_step_pulse,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_zero,
    output logic                         o_carry,
    output logic                         o_odd,
    output logic [BUS_WIDTH-1:0]         o_operand,
    output logic                         o_operand_oe,
    output logic                         o_running,
    output logic [COUNT_WIDTH-1:0]       o_retired
);

    localparam int OPERAND_WIDTH = BUS_WIDTH - INSTRUCTION_WIDTH;
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                   state, state_next;
    logic                     advance;
    logic [BUS_WIDTH-1:0]     ir;
    logic [STEP_WIDTH-1:0]    step, step_next;
    logic [COUNT_WIDTH-1:0]   retired, retired_next;
    logic                     zero, carry, odd;

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    assign advance = (state == RUN) && (!i_manual || i_step_pulse);
`else
    // Single-step inputs are kept on the port list but have no effect in this build.
    logic unused_single_step;
    assign unused_single_step = i_manual ^ i_step_pulse;
    assign advance = (state == RUN);
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        step_next    = step;
        retired_next = retired;
        if (advance) begin
            if (i_halt) begin
                state_next = HALTED;
            end else if (i_adv) begin
                step_next    = '0;
                retired_next = retired + COUNT_WIDTH'(1);
            end else if (step == LAST_STEP) begin
                step_next = '0;
            end else begin
                step_next = step + STEP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (i_reset) begin
            state   <= RUN;
            step    <= '0;
            retired <= '0;
            ir      <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            odd     <= 1'b0;
        end else begin
            state   <= state_next;
            step    <= step_next;
            retired <= retired_next;
            // Loads in the halting cycle still land; HALTED itself blocks them via advance.
            if (advance && i_instrregi) begin
                ir <= i_bus;
            end
            if (advance && i_alulatchf) begin
                {zero, carry, odd} <= {i_alu_zero, i_alu_carry, i_alu_odd};
            end
        end
    end

    assign o_instruction = ir[BUS_WIDTH-1 -: INSTRUCTION_WIDTH];
    assign o_operand     = BUS_WIDTH'(ir[OPERAND_WIDTH-1:0]);
    assign o_step        = step;
    assign o_zero        = zero;
    assign o_carry       = carry;
    assign o_odd         = odd;
    assign o_running     = (state == RUN);
    assign o_operand_oe  = i_instrrego && (state == RUN);
    assign o_retired     = retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver pushes hand-computed expected outputs per cycle,
// a monitor pops and compares them one time unit after each rising edge.
module tb_control_sequencer;

    typedef struct packed {
        logic [3:0]  instruction;
        logic [2:0]  step;
        logic        zero;
        logic        carry;
        logic        odd;
        logic [7:0]  operand;
        logic        oe;
        logic        running;
        logic [15:0] retired;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus;
    logic        ii, io, adv, halt, el;
    logic        alu_zero, alu_carry, alu_odd;
    logic        manual, step_pulse;
    logic [3:0]  instruction;
    logic [2:0]  step;
    logic        zero, carry, odd;
    logic [7:0]  operand;
    logic        operand_oe, running;
    logic [15:0] retired;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    exp_t  e;

    always #5 clk = ~clk;

    control_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_bus        (bus),
        .i_instrregi  (ii),
        .i_instrrego  (io),
        .i_adv        (adv),
        .i_halt       (halt),
        .i_alulatchf  (el),
        .i_alu_zero   (alu_zero),
        .i_alu_carry  (alu_carry),
        .i_alu_odd    (alu_odd),
        .i_manual     (manual),
        .i_step_pulse (step_pulse),
        .o_instruction(instruction),
        .o_step       (step),
        .o_zero       (zero),
        .o_carry      (carry),
        .o_odd        (odd),
        .o_operand    (operand),
        .o_operand_oe (operand_oe),
        .o_running    (running),
        .o_retired    (retired)
    );

    // Monitor: one expected snapshot per clock edge while the scoreboard holds entries.
    initial begin
        exp_t  want, got;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = '{instruction, step, zero, carry, odd, operand, operand_oe, running, retired};
                n_vec++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL %s: got ins=%h step=%0d zco=%b%b%b opd=%h oe=%b run=%b ret=%0d, want ins=%h step=%0d zco=%b%b%b opd=%h oe=%b run=%b ret=%0d",
                             nm, got.instruction, got.step, got.zero, got.carry, got.odd, got.operand,
                             got.oe, got.running, got.retired, want.instruction, want.step, want.zero,
                             want.carry, want.odd, want.operand, want.oe, want.running, want.retired);
                end
            end
        end
    end

    task automatic idle();
        reset = 1'b0; bus = 8'h00; ii = 1'b0; io = 1'b0; adv = 1'b0; halt = 1'b0; el = 1'b0;
        alu_zero = 1'b0; alu_carry = 1'b0; alu_odd = 1'b0; step_pulse = 1'b0;
    endtask

    // Queue the state expected after the coming edge, let the edge pass, then clear strobes.
    task automatic tick(input string nm, input exp_t want);
        exp_q.push_back(want);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    function automatic exp_t reset_exp();
        exp_t r;
        r = '0;
        r.running = 1'b1;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        manual = 1'b0;
        idle();
        reset = 1'b1;
        tick("reset_state", reset_exp());
        e = reset_exp();

        // 1: free-running step count with overflow wrap, retired untouched
        for (int k = 1; k <= 8; k++) begin
            e.step = 3'(k % 8);
            tick($sformatf("free_run_%0d", k), e);
        end

        // 2: II at step1, IO at step2, ADV at step4
        tick("pre_ii", '{4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0});
        bus = 8'h1A; ii = 1'b1;
        tick("ir_load", '{4'h1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 16'd0});
        io = 1'b1;
        tick("operand_oe_run", '{4'h1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b1, 16'd0});
        tick("step4", '{4'h1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 16'd0});
        adv = 1'b1;
        tick("adv_retire", '{4'h1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 16'd1});

        // 3: flag latch and hold through ADV
        tick("pre_el", '{4'h1, 3'd1, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 16'd1});
        el = 1'b1; alu_zero = 1'b1; alu_carry = 1'b0; alu_odd = 1'b1;
        tick("el_latch", '{4'h1, 3'd2, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 16'd1});
        alu_zero = 1'b0; alu_carry = 1'b1; alu_odd = 1'b0;
        tick("flags_hold", '{4'h1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 16'd1});
        adv = 1'b1;
        tick("flags_thru_adv", '{4'h1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 16'd2});
        tick("flags_later", '{4'h1, 3'd1, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 16'd2});
        el = 1'b1; alu_zero = 1'b0; alu_carry = 1'b1; alu_odd = 1'b0;
        tick("el_relatch", '{4'h1, 3'd2, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b1, 16'd2});

        // 4: halt with ADV, EL and II in the same cycle; then frozen
        halt = 1'b1; adv = 1'b1; el = 1'b1; ii = 1'b1; bus = 8'hF5;
        alu_zero = 1'b1; alu_carry = 1'b1; alu_odd = 1'b1;
        tick("halt_wins", '{4'hF, 3'd2, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 16'd2});
        for (int k = 0; k < 2; k++) begin
            ii = 1'b1; bus = 8'h33; el = 1'b1; io = 1'b1; adv = 1'b1;
            tick($sformatf("halted_frozen_%0d", k),
                 '{4'hF, 3'd2, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 16'd2});
        end
        reset = 1'b1;
        tick("reset_from_halt", reset_exp());

        // 5: reset mid-instruction with flags and IR loaded
        tick("r5_s1", '{4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0});
        el = 1'b1; alu_zero = 1'b1; alu_carry = 1'b1; alu_odd = 1'b1;
        tick("r5_s2", '{4'h0, 3'd2, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'd0});
        ii = 1'b1; bus = 8'h9C;
        tick("r5_s3", '{4'h9, 3'd3, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 16'd0});
        tick("r5_s4", '{4'h9, 3'd4, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 16'd0});
        tick("r5_s5", '{4'h9, 3'd5, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 16'd0});
        reset = 1'b1;
        tick("reset_mid_instr", reset_exp());

        // 6: manual single-step behaviour (build dependent)
        manual = 1'b1;
        e = reset_exp();
        s = 0;
        for (int k = 0; k < 10; k++) begin
`ifndef CONTROL_SEQUENCER_SINGLE_STEP_EN
            s = (s + 1) % 8;
`endif
            e.step = 3'(s);
            tick($sformatf("manual_idle_%0d", k), e);
        end
        for (int k = 0; k < 3; k++) begin
            step_pulse = 1'b1;
            s = (s + 1) % 8;
            e.step = 3'(s);
            tick($sformatf("manual_pulse_%0d", k), e);
`ifndef CONTROL_SEQUENCER_SINGLE_STEP_EN
            s = (s + 1) % 8;
`endif
            e.step = 3'(s);
            tick($sformatf("manual_gap_%0d", k), e);
        end
        el = 1'b1; alu_zero = 1'b1; alu_carry = 1'b1; alu_odd = 1'b1;
`ifndef CONTROL_SEQUENCER_SINGLE_STEP_EN
        s = (s + 1) % 8;
        e.zero = 1'b1; e.carry = 1'b1; e.odd = 1'b1;
`endif
        e.step = 3'(s);
        tick("manual_el_no_pulse", e);
        manual = 1'b0;
        s = (s + 1) % 8;
        e.step = 3'(s);
        tick("auto_resume", e);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
